// File: rtl/s27_bist_ctrl_if.sv
// Handshake/observation bundle between the s27 BIST controller and the
// s27 instance it exercises (plus the START/status side seen by the host).
interface s27_bist_ctrl_if;
   logic       START;
   logic       G0;
   logic       G1;
   logic       G2;
   logic       G3;
   logic       G17;
   logic       BUSY;
   logic       DONE;
   logic       PASS;
   logic [7:0] SIG;

   // Controller side: drives the s27 inputs and the status, observes G17.
   modport master (
      input  START,
      input  G17,
      output G0,
      output G1,
      output G2,
      output G3,
      output BUSY,
      output DONE,
      output PASS,
      output SIG
   );

   // Circuit/host side: supplies START and G17, observes the rest.
   modport slave (
      output START,
      output G17,
      input  G0,
      input  G1,
      input  G2,
      input  G3,
      input  BUSY,
      input  DONE,
      input  PASS,
      input  SIG
   );
endinterface

// File: rtl/s27_bist_ctrl.sv
// BIST controller for the s27 benchmark: initialises s27's flip-flops with two
// fixed vectors, applies PAT_COUNT LFSR patterns to G0..G3, compacts G17 into an
// 8-bit MISR and flags whether the final signature matches GOLDEN_SIG.
module s27_bist_ctrl #(
   parameter logic [7:0] PAT_COUNT  = 8'd200,
   parameter logic [7:0] LFSR_SEED  = 8'h01,
   parameter logic [7:0] GOLDEN_SIG = 8'h00
) (
   input  logic              CK,
   input  logic              RST,
   s27_bist_ctrl_if.master   bist
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INIT0 = 3'd1,
      ST_INIT1 = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } t_state;

   // Fibonacci step for x^8+x^6+x^5+x^4+1 (taps 7,5,4,3).
   function automatic logic [7:0] f_lfsr_step(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   // Same polynomial with the observed bit folded into bit 0.
   function automatic logic [7:0] f_misr_step(input logic [7:0] m, input logic d);
      return {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]} ^ {7'd0, d};
   endfunction

   t_state     r_state;
   t_state     w_state_nxt;
   logic [7:0] r_lfsr;
   logic [7:0] w_lfsr_nxt;
   logic [7:0] r_misr;
   logic [7:0] w_misr_nxt;
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_nxt;
   logic [3:0] r_vec;
   logic [3:0] w_vec_nxt;
   logic       r_busy;
   logic       w_busy_nxt;
   logic       r_done;
   logic       w_done_nxt;
   logic       r_pass;
   logic       w_pass_nxt;
   logic [7:0] w_lfsr_step;
   logic [7:0] w_misr_step;

   assign w_lfsr_step = f_lfsr_step(r_lfsr);
   assign w_misr_step = f_misr_step(r_misr, bist.G17);

   // Next-state and next-output decode; outputs are computed one edge ahead so
   // that every port comes straight from a flop.
   always_comb begin
      w_state_nxt = r_state;
      w_lfsr_nxt  = r_lfsr;
      w_misr_nxt  = r_misr;
      w_cnt_nxt   = r_cnt;
      w_vec_nxt   = 4'b0000;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_pass_nxt  = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (bist.START) begin
               w_state_nxt = ST_INIT0;
               w_lfsr_nxt  = LFSR_SEED;
               w_misr_nxt  = 8'h00;
               w_cnt_nxt   = 8'd0;
               w_vec_nxt   = 4'b1110;   // clears s27 G5 and G7
               w_busy_nxt  = 1'b1;
            end else begin
               w_done_nxt  = (r_state == ST_DONE);
               w_pass_nxt  = (r_state == ST_DONE) ? r_pass : 1'b0;
            end
         end
         ST_INIT0: begin
            w_state_nxt = ST_INIT1;
            w_vec_nxt   = 4'b1100;      // sets s27 G6, keeps G5/G7 clear
            w_busy_nxt  = 1'b1;
         end
         ST_INIT1: begin
            w_state_nxt = ST_RUN;
            w_vec_nxt   = r_lfsr[3:0];
            w_busy_nxt  = 1'b1;
         end
         ST_RUN: begin
            w_misr_nxt = w_misr_step;
            w_lfsr_nxt = w_lfsr_step;
            w_cnt_nxt  = r_cnt + 8'd1;
            if (r_cnt == (PAT_COUNT - 8'd1)) begin
               w_state_nxt = ST_DONE;
               w_done_nxt  = 1'b1;
               w_pass_nxt  = (w_misr_step == GOLDEN_SIG);
            end else begin
               w_vec_nxt   = w_lfsr_step[3:0];
               w_busy_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Pattern generator, signature register, counter and registered outputs.
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         r_lfsr <= LFSR_SEED;
         r_misr <= 8'h00;
         r_cnt  <= 8'd0;
         r_vec  <= 4'b0000;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_pass <= 1'b0;
      end else begin
         r_lfsr <= w_lfsr_nxt;
         r_misr <= w_misr_nxt;
         r_cnt  <= w_cnt_nxt;
         r_vec  <= w_vec_nxt;
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
         r_pass <= w_pass_nxt;
      end
   end

   assign bist.G0   = r_vec[0];
   assign bist.G1   = r_vec[1];
   assign bist.G2   = r_vec[2];
   assign bist.G3   = r_vec[3];
   assign bist.BUSY = r_busy;
   assign bist.DONE = r_done;
   assign bist.PASS = r_pass;
   assign bist.SIG  = r_misr;

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Scoreboard bench for s27_bist_ctrl: three controllers (PAT_COUNT 200/1/2),
// the 200-pattern one optionally wired to a behavioural s27.
module tb_s27_bist_ctrl;

   localparam logic [7:0] C_SEED = 8'h01;

   // s27 netlist: returns {next G5, next G6, next G7, G17}; st = {G5,G6,G7}.
   function automatic logic [3:0] f_s27(input logic [2:0] st, input logic [3:0] v);
      logic g5, g6, g7, g8, g9, g10, g11, g12, g13, g14, g15, g16;
      g5  = st[2];
      g6  = st[1];
      g7  = st[0];
      g14 = ~v[0];
      g12 = ~(v[1] | g7);
      g13 = ~(v[2] | g12);
      g8  = g14 & g6;
      g15 = g12 | g8;
      g16 = v[3] | g8;
      g9  = ~(g16 & g15);
      g11 = ~(g5 | g9);
      g10 = ~(g14 | g11);
      return {g10, g11, g13, ~g11};
   endfunction

   // Expected signature of one complete test, assuming s27 starts RUN at (0,1,0).
   function automatic logic [7:0] f_ref(input int pat, input logic [3:0] mask,
                                        input logic use_s27, input logic inv);
      logic [7:0] l;
      logic [7:0] m;
      logic [2:0] st;
      logic [3:0] r;
      logic       g;
      l  = C_SEED;
      m  = 8'h00;
      st = 3'b010;
      for (int i = 0; i < pat; i++) begin
         r = f_s27(st, l[3:0]);
         g = use_s27 ? r[0] : ^(l[3:0] & mask);
         g = g ^ inv;
         if (use_s27) st = r[3:1];
         m = {m[6:0], ^(m & 8'hB8)} ^ {7'd0, g};
         l = {l[6:0], ^(l & 8'hB8)};
      end
      return m;
   endfunction

   localparam logic [7:0] C_GOLD_A = f_ref(200, 4'h0, 1'b1, 1'b0);

   typedef struct {
      logic [7:0] sig;
      logic       pass;
      int         cyc;
   } t_exp;

   logic       CK = 1'b0;
   logic       RST = 1'b1;
   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;

   logic [2:0] start_s;
   logic [2:0] g17_s;
   logic [2:0] busy_s;
   logic [2:0] done_s;
   logic [2:0] pass_s;
   logic [2:0] inv_k;
   logic [3:0] vec_s [3];
   logic [7:0] sig_s [3];
   logic [3:0] mask_k [3];
   int         pat_k [3];
   logic [7:0] gold_k [3];
   logic       use_s27_a;
   logic [2:0] s27_st = 3'b101;
   logic [3:0] s27_r;
   t_exp       q_exp [3][$];

   s27_bist_ctrl_if if_a ();
   s27_bist_ctrl_if if_b ();
   s27_bist_ctrl_if if_c ();

   s27_bist_ctrl #(.PAT_COUNT(8'd200), .LFSR_SEED(C_SEED), .GOLDEN_SIG(C_GOLD_A))
      u_dut_a (.CK(CK), .RST(RST), .bist(if_a.master));
   s27_bist_ctrl #(.PAT_COUNT(8'd1), .LFSR_SEED(C_SEED), .GOLDEN_SIG(8'h00))
      u_dut_b (.CK(CK), .RST(RST), .bist(if_b.master));
   s27_bist_ctrl #(.PAT_COUNT(8'd2), .LFSR_SEED(C_SEED), .GOLDEN_SIG(8'h00))
      u_dut_c (.CK(CK), .RST(RST), .bist(if_c.master));

   always #5 CK = ~CK;

   always @(posedge CK) cyc <= cyc + 1;

   // behavioural s27 beside controller A, no reset of its own
   assign s27_r = f_s27(s27_st, vec_s[0]);
   always @(posedge CK) s27_st <= s27_r[3:1];

   assign g17_s[0] = (use_s27_a ? s27_r[0] : ^(vec_s[0] & mask_k[0])) ^ inv_k[0];
   assign g17_s[1] = ^(vec_s[1] & mask_k[1]) ^ inv_k[1];
   assign g17_s[2] = ^(vec_s[2] & mask_k[2]) ^ inv_k[2];

   assign if_a.START = start_s[0];
   assign if_b.START = start_s[1];
   assign if_c.START = start_s[2];
   assign if_a.G17   = g17_s[0];
   assign if_b.G17   = g17_s[1];
   assign if_c.G17   = g17_s[2];
   assign vec_s[0]   = {if_a.G3, if_a.G2, if_a.G1, if_a.G0};
   assign vec_s[1]   = {if_b.G3, if_b.G2, if_b.G1, if_b.G0};
   assign vec_s[2]   = {if_c.G3, if_c.G2, if_c.G1, if_c.G0};
   assign busy_s     = {if_c.BUSY, if_b.BUSY, if_a.BUSY};
   assign done_s     = {if_c.DONE, if_b.DONE, if_a.DONE};
   assign pass_s     = {if_c.PASS, if_b.PASS, if_a.PASS};
   assign sig_s[0]   = if_a.SIG;
   assign sig_s[1]   = if_b.SIG;
   assign sig_s[2]   = if_c.SIG;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_idle_outputs(input int k, input string tag);
      chk($sformatf("%s_vec%0d", tag, k), 32'(vec_s[k]), 32'd0);
      chk($sformatf("%s_busy%0d", tag, k), 32'(busy_s[k]), 32'd0);
      chk($sformatf("%s_done%0d", tag, k), 32'(done_s[k]), 32'd0);
      chk($sformatf("%s_pass%0d", tag, k), 32'(pass_s[k]), 32'd0);
      chk($sformatf("%s_sig%0d", tag, k), 32'(sig_s[k]), 32'd0);
   endtask

   // Pulse START for one edge and push the expected result of that test.
   task automatic issue(input int k);
      t_exp       e;
      logic [7:0] s;
      @(negedge CK);
      start_s[k] = 1'b1;
      @(posedge CK);
      #1;
      start_s[k] = 1'b0;
      s      = f_ref(pat_k[k], mask_k[k], (k == 0) ? use_s27_a : 1'b0, inv_k[k]);
      e.sig  = s;
      e.pass = (s == gold_k[k]);
      e.cyc  = cyc + 2 + pat_k[k];
      q_exp[k].push_back(e);
      chk($sformatf("busy_after_start%0d", k), 32'(busy_s[k]), 32'd1);
   endtask

   task automatic drain(input int k, input int budget);
      int n;
      n = 0;
      while (q_exp[k].size() != 0 && n < budget) begin
         @(posedge CK);
         n++;
      end
      if (q_exp[k].size() != 0) begin
         chk($sformatf("timeout%0d", k), 32'(q_exp[k].size()), 32'd0);
         q_exp[k].delete();
      end
   endtask

   // Monitor: on each DONE rise pop the oldest expectation and compare.
   initial begin
      logic [2:0] prev_done;
      t_exp       e;
      prev_done = 3'b000;
      forever begin
         @(negedge CK);
         for (int k = 0; k < 3; k++) begin
            if (done_s[k] && !prev_done[k]) begin
               if (q_exp[k].size() == 0) begin
                  chk($sformatf("unexpected_done%0d", k), 32'd1, 32'd0);
               end else begin
                  e = q_exp[k].pop_front();
                  chk($sformatf("sig%0d", k), 32'(sig_s[k]), 32'(e.sig));
                  chk($sformatf("pass%0d", k), 32'(pass_s[k]), 32'(e.pass));
                  chk($sformatf("done_cycle%0d", k), 32'(cyc), 32'(e.cyc));
                  chk($sformatf("done_vec%0d", k), 32'(vec_s[k]), 32'd0);
                  chk($sformatf("done_busy%0d", k), 32'(busy_s[k]), 32'd0);
               end
            end
         end
         prev_done = done_s;
      end
   end

   // Stimulus sequence.
   initial begin
      logic [7:0] l;
      start_s   = 3'b000;
      inv_k     = 3'b000;
      use_s27_a = 1'b0;
      pat_k     = '{200, 1, 2};
      gold_k    = '{C_GOLD_A, 8'h00, 8'h00};
      for (int k = 0; k < 3; k++) mask_k[k] = 4'h0;

      repeat (3) @(posedge CK);
      #1;
      for (int k = 0; k < 3; k++) chk_idle_outputs(k, "reset");
      @(negedge CK);
      RST = 1'b0;

      // G17 stuck at 0 on the 200-pattern controller
      issue(0);
      drain(0, 300);

      // G17 stuck at 1 on the 1- and 2-pattern controllers
      inv_k[1] = 1'b1;
      inv_k[2] = 1'b1;
      issue(1);
      issue(2);
      drain(1, 20);
      drain(2, 20);

      // real s27: initialisation vectors, s27 state and first RUN vectors
      use_s27_a = 1'b1;
      issue(0);
      chk("init0_vec", 32'(vec_s[0]), 32'b1110);
      @(posedge CK);
      #1;
      chk("init1_vec", 32'(vec_s[0]), 32'b1100);
      @(posedge CK);
      #1;
      chk("s27_state_run0", 32'(s27_st), 32'b010);
      l = C_SEED;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("run_vec%0d", i), 32'(vec_s[0]), 32'(l[3:0]));
         l = {l[6:0], ^(l & 8'hB8)};
         @(posedge CK);
         #1;
      end
      drain(0, 300);

      // inverted G17 against the real-s27 golden signature
      inv_k[0] = 1'b1;
      issue(0);
      drain(0, 300);
      inv_k[0] = 1'b0;

      // START held during RUN must change nothing
      issue(0);
      repeat (10) @(posedge CK);
      @(negedge CK);
      start_s[0] = 1'b1;
      repeat (30) @(negedge CK);
      start_s[0] = 1'b0;
      drain(0, 300);

      // asynchronous reset in RUN cycle 50, then a clean rerun
      issue(0);
      repeat (52) @(posedge CK);
      #3;
      RST = 1'b1;
      #1;
      chk_idle_outputs(0, "midrst");
      for (int k = 0; k < 3; k++) q_exp[k].delete();
      @(negedge CK);
      RST = 1'b0;
      issue(0);
      drain(0, 300);

      // randomised G17 functions of the applied vector
      for (int n = 0; n < 6; n++) begin
         for (int k = 1; k < 3; k++) begin
            mask_k[k] = 4'($urandom_range(15, 0));
            inv_k[k]  = 1'($urandom_range(1, 0));
         end
         issue(1);
         issue(2);
         drain(1, 20);
         drain(2, 20);
      end
      use_s27_a = 1'b0;
      for (int n = 0; n < 2; n++) begin
         mask_k[0] = 4'($urandom_range(15, 1));
         inv_k[0]  = 1'($urandom_range(1, 0));
         issue(0);
         drain(0, 300);
      end

      repeat (3) @(posedge CK);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
